// File: rtl/hdlc_tx_framer_if.sv
// Byte-side handshake and serial line of the HDLC transmit framer.
// The master drives bytes and abort requests; the slave (framer) drives the line and status pulses.
interface hdlc_tx_framer_if;
  logic [7:0] Tx_Data;
  logic       Tx_DataValid;
  logic       Tx_LastByte;
  logic       Tx_AbortFrame;
  logic       Tx;
  logic       Tx_NewByte;
  logic       Tx_ValidFrame;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;

  modport master (
    output Tx_Data, Tx_DataValid, Tx_LastByte, Tx_AbortFrame,
    input  Tx, Tx_NewByte, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );

  modport slave (
    input  Tx_Data, Tx_DataValid, Tx_LastByte, Tx_AbortFrame,
    output Tx, Tx_NewByte, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );
endinterface

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: start flag, LSB-first data with zero insertion, end flag or abort pattern.
// The registered state always describes the bit currently on Tx.
//
// state        | meaning
// S_IDLE       | line idles at 1, waiting for Tx_DataValid
// S_START_FLAG | Tx carries start-flag bit cnt_q (01111110)
// S_DATA       | Tx carries data bit cnt_q of shreg_q, or a stuffed 0 after it
// S_END_FLAG   | Tx carries end-flag bit cnt_q
// S_ABORT      | Tx carries abort-pattern bit cnt_q (01111111)
module hdlc_tx_framer (
  input  logic            Clk,
  input  logic            Rst,
  hdlc_tx_framer_if.slave tx_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_FLAG,
    S_DATA,
    S_END_FLAG,
    S_ABORT
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] ones_q, ones_d;
  logic       stuff_q, stuff_d;
  logic       last_q, last_d;
  logic       tx_q, tx_d;

  logic [2:0] cnt_inc;
  logic       load_byte;
  logic       enter_abort;

  function automatic logic flag_bit(input logic [2:0] idx);
    return (idx != 3'd0) && (idx != 3'd7);
  endfunction

  function automatic logic [2:0] ones_next(input logic [2:0] ones, input logic b);
    return b ? ones + 3'd1 : 3'd0;
  endfunction

  assign cnt_inc = cnt_q + 3'd1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      shreg_q <= 8'h00;
      ones_q  <= 3'd0;
      stuff_q <= 1'b0;
      last_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ones_q  <= ones_d;
      stuff_q <= stuff_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ones_d      = ones_q;
    stuff_d     = stuff_q;
    last_d      = last_q;
    tx_d        = 1'b1;
    load_byte   = 1'b0;
    enter_abort = 1'b0;

    case (state_q)
      S_IDLE: begin
        ones_d  = 3'd0;
        stuff_d = 1'b0;
        if (tx_if.Tx_DataValid) begin
          state_d = S_START_FLAG;
          cnt_d   = 3'd0;
          tx_d    = 1'b0;
        end
      end

      S_START_FLAG: begin
        if (tx_if.Tx_AbortFrame) begin
          enter_abort = 1'b1;
        end else if (cnt_q != 3'd7) begin
          cnt_d = cnt_inc;
          tx_d  = flag_bit(cnt_inc);
        end else if (tx_if.Tx_DataValid) begin
          load_byte = 1'b1;
        end else begin
          enter_abort = 1'b1;
        end
      end

      S_DATA: begin
        // A pending stuff bit goes out before the next data bit, byte or end flag.
        if (tx_if.Tx_AbortFrame) begin
          enter_abort = 1'b1;
        end else if (!stuff_q && (ones_q == 3'd5)) begin
          stuff_d = 1'b1;
          tx_d    = 1'b0;
          ones_d  = 3'd0;
        end else if (cnt_q != 3'd7) begin
          cnt_d   = cnt_inc;
          stuff_d = 1'b0;
          tx_d    = shreg_q[cnt_inc];
          ones_d  = ones_next(ones_q, shreg_q[cnt_inc]);
        end else if (last_q) begin
          state_d = S_END_FLAG;
          cnt_d   = 3'd0;
          stuff_d = 1'b0;
          ones_d  = 3'd0;
          tx_d    = 1'b0;
        end else if (tx_if.Tx_DataValid) begin
          load_byte = 1'b1;
        end else begin
          enter_abort = 1'b1;
        end
      end

      S_END_FLAG: begin
        if (cnt_q != 3'd7) begin
          cnt_d = cnt_inc;
          tx_d  = flag_bit(cnt_inc);
        end else begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end
      end

      S_ABORT: begin
        if (cnt_q != 3'd7) begin
          cnt_d = cnt_inc;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    if (enter_abort) begin
      state_d = S_ABORT;
      cnt_d   = 3'd0;
      tx_d    = 1'b0;
      ones_d  = 3'd0;
      stuff_d = 1'b0;
    end

    if (load_byte) begin
      state_d = S_DATA;
      shreg_d = tx_if.Tx_Data;
      last_d  = tx_if.Tx_LastByte;
      cnt_d   = 3'd0;
      stuff_d = 1'b0;
      tx_d    = tx_if.Tx_Data[0];
      ones_d  = ones_next(ones_q, tx_if.Tx_Data[0]);
    end
  end

  assign tx_if.Tx              = tx_q;
  assign tx_if.Tx_NewByte      = load_byte;
  assign tx_if.Tx_ValidFrame   = (state_q == S_START_FLAG) || (state_q == S_DATA) ||
                                 (state_q == S_END_FLAG);
  assign tx_if.Tx_Done         = (state_q == S_END_FLAG) && (cnt_q == 3'd7);
  assign tx_if.Tx_AbortedTrans = (state_q == S_ABORT) && (cnt_q == 3'd0);

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: each scenario captures 48 cycles of line/status
// activity and compares them against hand-built expected bit sequences.
module tb_hdlc_tx_framer;
  localparam int NC = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hdlc_tx_framer_if bus ();
  hdlc_tx_framer dut (.Clk(clk), .Rst(rst), .tx_if(bus));

  always #5 clk = ~clk;

  logic [0:NC-1] cap_tx, cap_vf, cap_nb, cap_done, cap_ab;
  logic [0:NC-1] e_tx, e_vf, e_nb, e_done, e_ab;

  // Cycle 0 presents the first byte in IDLE; index c of each capture is cycle c.
  task automatic run_frame(input logic [7:0] d0, input logic [7:0] d1, input int nbytes,
                           input int abort_cycle, input int drop_idx, input bit rearm);
    int idx;
    idx = 0;
    cap_tx = '0; cap_vf = '0; cap_nb = '0; cap_done = '0; cap_ab = '0;
    bus.Tx_Data = d0;
    bus.Tx_LastByte = (nbytes == 1);
    bus.Tx_DataValid = 1'b1;
    for (int c = 0; c < NC; c++) begin
      bus.Tx_AbortFrame = (c == abort_cycle);
      @(negedge clk);
      cap_tx[c] = bus.Tx;
      cap_vf[c] = bus.Tx_ValidFrame;
      cap_nb[c] = bus.Tx_NewByte;
      cap_done[c] = bus.Tx_Done;
      cap_ab[c] = bus.Tx_AbortedTrans;
      if (bus.Tx_NewByte) idx++;
      @(posedge clk); #1;
      if (abort_cycle >= 0 && c >= abort_cycle) begin
        bus.Tx_DataValid = 1'b0; bus.Tx_LastByte = 1'b0;
      end else if (idx < nbytes && idx != drop_idx) begin
        bus.Tx_DataValid = 1'b1;
        bus.Tx_Data = (idx == 0) ? d0 : d1;
        bus.Tx_LastByte = (idx == nbytes - 1);
      end else if (rearm && idx == nbytes) begin
        bus.Tx_DataValid = 1'b1; bus.Tx_Data = d1; bus.Tx_LastByte = 1'b1;
      end else begin
        bus.Tx_DataValid = 1'b0; bus.Tx_LastByte = 1'b0;
      end
    end
    bus.Tx_DataValid = 1'b0;
    bus.Tx_LastByte = 1'b0;
    bus.Tx_AbortFrame = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.Tx_Data = 8'hFF; bus.Tx_DataValid = 1'b1; bus.Tx_LastByte = 1'b1; bus.Tx_AbortFrame = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({bus.Tx, bus.Tx_NewByte, bus.Tx_ValidFrame, bus.Tx_Done, bus.Tx_AbortedTrans} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 10000",
               {bus.Tx, bus.Tx_NewByte, bus.Tx_ValidFrame, bus.Tx_Done, bus.Tx_AbortedTrans});
    end
    bus.Tx_DataValid = 1'b0; bus.Tx_LastByte = 1'b0; bus.Tx_AbortFrame = 1'b0;
    rst = 1'b0;
  endtask

  // Runs straight after reset release: the first edge with Tx_DataValid starts the frame.
  task automatic test_single_55();
    run_frame(8'h55, 8'h00, 1, -1, -1, 1'b0);
    e_tx   = {1'b1, 8'b01111110, 8'b10101010, 8'b01111110, {23{1'b1}}};
    e_vf   = {1'b0, {24{1'b1}}, 23'b0};
    e_nb   = {8'b0, 1'b1, 39'b0};
    e_done = {24'b0, 1'b1, 23'b0};
    e_ab   = '0;
    checks++; if (cap_tx !== e_tx) begin errors++; $display("FAIL single55_tx: got %b expected %b", cap_tx, e_tx); end
    checks++; if (cap_vf !== e_vf) begin errors++; $display("FAIL single55_valid: got %b expected %b", cap_vf, e_vf); end
    checks++; if (cap_nb !== e_nb) begin errors++; $display("FAIL single55_newbyte: got %b expected %b", cap_nb, e_nb); end
    checks++; if (cap_done !== e_done) begin errors++; $display("FAIL single55_done: got %b expected %b", cap_done, e_done); end
    checks++; if (cap_ab !== e_ab) begin errors++; $display("FAIL single55_aborted: got %b expected %b", cap_ab, e_ab); end
  endtask

  task automatic test_reset_mid_frame();
    logic [0:19] idle_tx;
    logic [0:19] idle_pulses;
    bus.Tx_Data = 8'h7F; bus.Tx_LastByte = 1'b1; bus.Tx_DataValid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.Tx, bus.Tx_ValidFrame} !== 2'b11) begin
      errors++; $display("FAIL midreset_pre: got %b expected 11", {bus.Tx, bus.Tx_ValidFrame});
    end
    bus.Tx_DataValid = 1'b0; bus.Tx_LastByte = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.Tx, bus.Tx_NewByte, bus.Tx_ValidFrame, bus.Tx_Done, bus.Tx_AbortedTrans} !== 5'b10000) begin
      errors++;
      $display("FAIL midreset_immediate: got %b expected 10000",
               {bus.Tx, bus.Tx_NewByte, bus.Tx_ValidFrame, bus.Tx_Done, bus.Tx_AbortedTrans});
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle_tx[i] = bus.Tx;
      idle_pulses[i] = bus.Tx_NewByte | bus.Tx_ValidFrame | bus.Tx_Done | bus.Tx_AbortedTrans;
    end
    @(posedge clk); #1;
    checks++; if (idle_tx !== 20'hFFFFF) begin errors++; $display("FAIL midreset_idle_tx: got %b expected all ones", idle_tx); end
    checks++; if (idle_pulses !== 20'h00000) begin errors++; $display("FAIL midreset_idle_status: got %b expected all zeros", idle_pulses); end
  endtask

  task automatic test_single_ff();
    run_frame(8'hFF, 8'h00, 1, -1, -1, 1'b0);
    e_tx   = {1'b1, 8'b01111110, 9'b111110111, 8'b01111110, {22{1'b1}}};
    e_vf   = {1'b0, {25{1'b1}}, 22'b0};
    e_nb   = {8'b0, 1'b1, 39'b0};
    e_done = {25'b0, 1'b1, 22'b0};
    checks++; if (cap_tx !== e_tx) begin errors++; $display("FAIL singleFF_tx: got %b expected %b", cap_tx, e_tx); end
    checks++; if (cap_vf !== e_vf) begin errors++; $display("FAIL singleFF_valid: got %b expected %b", cap_vf, e_vf); end
    checks++; if (cap_nb !== e_nb) begin errors++; $display("FAIL singleFF_newbyte: got %b expected %b", cap_nb, e_nb); end
    checks++; if (cap_done !== e_done) begin errors++; $display("FAIL singleFF_done: got %b expected %b", cap_done, e_done); end
  endtask

  task automatic test_stuff_boundary();
    run_frame(8'hF8, 8'h07, 2, -1, -1, 1'b0);
    e_tx   = {1'b1, 8'b01111110, 8'b00011111, 1'b0, 8'b11100000, 8'b01111110, {14{1'b1}}};
    e_vf   = {1'b0, {33{1'b1}}, 14'b0};
    e_nb   = {8'b0, 1'b1, 8'b0, 1'b1, 30'b0};
    e_done = {33'b0, 1'b1, 14'b0};
    e_ab   = '0;
    checks++; if (cap_tx !== e_tx) begin errors++; $display("FAIL boundary_tx: got %b expected %b", cap_tx, e_tx); end
    checks++; if (cap_vf !== e_vf) begin errors++; $display("FAIL boundary_valid: got %b expected %b", cap_vf, e_vf); end
    checks++; if (cap_nb !== e_nb) begin errors++; $display("FAIL boundary_newbyte: got %b expected %b", cap_nb, e_nb); end
    checks++; if (cap_done !== e_done) begin errors++; $display("FAIL boundary_done: got %b expected %b", cap_done, e_done); end
    checks++; if (cap_ab !== e_ab) begin errors++; $display("FAIL boundary_aborted: got %b expected %b", cap_ab, e_ab); end
  endtask

  // Abort while bit 3 of 0xAA is on the line, with a second byte still pending.
  task automatic test_abort_data();
    run_frame(8'hAA, 8'h33, 2, 12, -1, 1'b0);
    e_tx   = {1'b1, 8'b01111110, 4'b0101, 1'b0, {34{1'b1}}};
    e_vf   = {1'b0, {12{1'b1}}, 35'b0};
    e_nb   = {8'b0, 1'b1, 39'b0};
    e_done = '0;
    e_ab   = {13'b0, 1'b1, 34'b0};
    checks++; if (cap_tx !== e_tx) begin errors++; $display("FAIL abortdata_tx: got %b expected %b", cap_tx, e_tx); end
    checks++; if (cap_vf !== e_vf) begin errors++; $display("FAIL abortdata_valid: got %b expected %b", cap_vf, e_vf); end
    checks++; if (cap_nb !== e_nb) begin errors++; $display("FAIL abortdata_newbyte: got %b expected %b", cap_nb, e_nb); end
    checks++; if (cap_done !== e_done) begin errors++; $display("FAIL abortdata_done: got %b expected %b", cap_done, e_done); end
    checks++; if (cap_ab !== e_ab) begin errors++; $display("FAIL abortdata_aborted: got %b expected %b", cap_ab, e_ab); end
  endtask

  // Abort coincides with the end of the start flag while a byte is valid.
  task automatic test_abort_at_consume();
    run_frame(8'h55, 8'h00, 1, 8, -1, 1'b0);
    e_tx = {1'b1, 8'b01111110, 1'b0, {38{1'b1}}};
    e_vf = {1'b0, {8{1'b1}}, 39'b0};
    e_nb = '0;
    e_ab = {9'b0, 1'b1, 38'b0};
    checks++; if (cap_tx !== e_tx) begin errors++; $display("FAIL abortconsume_tx: got %b expected %b", cap_tx, e_tx); end
    checks++; if (cap_vf !== e_vf) begin errors++; $display("FAIL abortconsume_valid: got %b expected %b", cap_vf, e_vf); end
    checks++; if (cap_nb !== e_nb) begin errors++; $display("FAIL abortconsume_newbyte: got %b expected %b", cap_nb, e_nb); end
    checks++; if (cap_ab !== e_ab) begin errors++; $display("FAIL abortconsume_aborted: got %b expected %b", cap_ab, e_ab); end
  endtask

  // Underrun alone, then underrun plus abort request in the same cycle: identical line result.
  task automatic test_underrun();
    e_tx   = {1'b1, 8'b01111110, 8'h00, 1'b0, {30{1'b1}}};
    e_vf   = {1'b0, {16{1'b1}}, 31'b0};
    e_nb   = {8'b0, 1'b1, 39'b0};
    e_done = '0;
    e_ab   = {17'b0, 1'b1, 30'b0};
    for (int k = 0; k < 2; k++) begin
      run_frame(8'h00, 8'h11, 2, (k == 0) ? -1 : 16, 1, 1'b0);
      checks++; if (cap_tx !== e_tx) begin errors++; $display("FAIL underrun%0d_tx: got %b expected %b", k, cap_tx, e_tx); end
      checks++; if (cap_vf !== e_vf) begin errors++; $display("FAIL underrun%0d_valid: got %b expected %b", k, cap_vf, e_vf); end
      checks++; if (cap_nb !== e_nb) begin errors++; $display("FAIL underrun%0d_newbyte: got %b expected %b", k, cap_nb, e_nb); end
      checks++; if (cap_done !== e_done) begin errors++; $display("FAIL underrun%0d_done: got %b expected %b", k, cap_done, e_done); end
      checks++; if (cap_ab !== e_ab) begin errors++; $display("FAIL underrun%0d_aborted: got %b expected %b", k, cap_ab, e_ab); end
    end
  endtask

  task automatic test_abort_ignored_end_flag();
    run_frame(8'h55, 8'h00, 1, 20, -1, 1'b0);
    e_tx   = {1'b1, 8'b01111110, 8'b10101010, 8'b01111110, {23{1'b1}}};
    e_done = {24'b0, 1'b1, 23'b0};
    e_ab   = '0;
    checks++; if (cap_tx !== e_tx) begin errors++; $display("FAIL endabort_tx: got %b expected %b", cap_tx, e_tx); end
    checks++; if (cap_done !== e_done) begin errors++; $display("FAIL endabort_done: got %b expected %b", cap_done, e_done); end
    checks++; if (cap_ab !== e_ab) begin errors++; $display("FAIL endabort_aborted: got %b expected %b", cap_ab, e_ab); end
  endtask

  // Next frame's byte is valid as soon as the first is consumed; one idle bit must separate them.
  task automatic test_back_to_back();
    run_frame(8'h55, 8'h0F, 1, -1, -1, 1'b1);
    e_tx   = {1'b1, 8'b01111110, 8'b10101010, 8'b01111110, 1'b1,
              8'b01111110, 8'b11110000, 6'b011111};
    e_vf   = {1'b0, {24{1'b1}}, 1'b0, {22{1'b1}}};
    e_nb   = {8'b0, 1'b1, 24'b0, 1'b1, 14'b0};
    e_done = {24'b0, 1'b1, 23'b0};
    checks++; if (cap_tx !== e_tx) begin errors++; $display("FAIL b2b_tx: got %b expected %b", cap_tx, e_tx); end
    checks++; if (cap_vf !== e_vf) begin errors++; $display("FAIL b2b_valid: got %b expected %b", cap_vf, e_vf); end
    checks++; if (cap_nb !== e_nb) begin errors++; $display("FAIL b2b_newbyte: got %b expected %b", cap_nb, e_nb); end
    checks++; if (cap_done !== e_done) begin errors++; $display("FAIL b2b_done: got %b expected %b", cap_done, e_done); end
  endtask

  initial begin
    bus.Tx_Data = 8'h00;
    bus.Tx_DataValid = 1'b0;
    bus.Tx_LastByte = 1'b0;
    bus.Tx_AbortFrame = 1'b0;
    test_reset();
    test_single_55();
    test_reset_mid_frame();
    test_single_ff();
    test_stuff_boundary();
    test_abort_data();
    test_abort_at_consume();
    test_underrun();
    test_abort_ignored_end_flag();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_framer.md
HDLC_TX_FRAMER -- requirements
Module: hdlc_tx_framer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports are:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous reset, active-high
- Tx_Data  in  8  byte to transmit; LSB is sent first
- Tx_DataValid  in  1  Tx_Data is valid; held until consumed
- Tx_LastByte  in  1  qualifies Tx_Data as the final byte of the frame
- Tx_AbortFrame  in  1  request to abort the frame in progress
- Tx  out  1  serial HDLC line, registered
- Tx_NewByte  out  1  one-cycle pulse: Tx_Data/Tx_LastByte consumed this cycle
- Tx_ValidFrame  out  1  frame in progress (flags included)
- Tx_Done  out  1  one-cycle pulse: frame completed normally
- Tx_AbortedTrans  out  1  one-cycle pulse: frame aborted

Function
REQ-002 The FSM SHALL have the states IDLE, START_FLAG, DATA, END_FLAG and ABORT; one line bit is driven per clock.
REQ-003 In IDLE the block SHALL drive Tx=1 continuously.
REQ-004 In IDLE, Tx_DataValid=1 at cycle N SHALL start START_FLAG, with the first flag bit on Tx at N+1.
REQ-005 START_FLAG and END_FLAG SHALL each drive 0,1,1,1,1,1,1,0 on Tx over 8 consecutive cycles, with no zero insertion.
REQ-006 A byte SHALL be consumed (Tx_NewByte=1, Tx_DataValid=1) in the cycle the last bit of the preceding unit is on Tx; that unit is the start flag, or the prior byte including any trailing stuffed zero. Bit0 of the new byte SHALL appear on Tx the next cycle.
REQ-007 Tx_NewByte SHALL never pulse when Tx_DataValid=0, in IDLE, END_FLAG or ABORT, or after the byte tagged Tx_LastByte.
REQ-008 Zero insertion:
- A 3-bit counter SHALL count consecutive 1 data bits driven on Tx in DATA.
- When the counter reaches 5, the next Tx bit SHALL be an inserted 0; serialization pauses one cycle and the counter clears.
- The counter SHALL persist across byte boundaries within a frame.
- The counter SHALL be cleared by any 0 data bit, by flags and by abort.
REQ-009 A stuffed zero owed after a byte's final bit SHALL be sent before the next byte or the end flag, delaying consumption by one cycle.
REQ-010 After the last bit (or stuff bit) of the Tx_LastByte byte, the FSM SHALL enter END_FLAG; after its 8th bit it SHALL return to IDLE, and Tx_Done SHALL pulse in the cycle the final flag bit is on Tx.
REQ-011 Tx_ValidFrame SHALL be 1 exactly while Tx carries start-flag, data/stuff, or end-flag bits.
REQ-012 Underrun: Tx_DataValid=0 at a REQ-006 consumption point (no last byte yet) SHALL be treated as an abort at that cycle.
REQ-013 Tx_AbortFrame=1 at cycle N in START_FLAG or DATA SHALL:
- abandon the current bit position;
- drive 0 at N+1, then 1 for N+2..N+8 (abort pattern 01111111);
- pulse Tx_AbortedTrans at N+1;
- return to IDLE after N+8.
REQ-014 Tx_ValidFrame SHALL fall at N+1 on abort; Tx_Done SHALL NOT pulse for an aborted frame.
REQ-015 Tx_AbortFrame SHALL be ignored in IDLE, END_FLAG and ABORT.
REQ-016 Simultaneous abort and consumption point SHALL abort without consuming the byte; abort plus underrun SHALL yield a single Tx_AbortedTrans pulse.
REQ-017 A new frame SHALL NOT start before IDLE is re-entered; IDLE lasts at least 1 cycle between frames.

Reset
REQ-018 Rst=1 SHALL immediately set Tx=1, Tx_NewByte=0, Tx_ValidFrame=0, Tx_Done=0 and Tx_AbortedTrans=0, FSM=IDLE, and ones counter=0, including mid-frame (no flag or abort emitted).
REQ-019 After Rst falls, the first frame SHALL be able to start on the first rising edge with Tx_DataValid=1.

Verification
REQ-020 Reset mid-DATA -> Tx=1 in the same cycle, all pulses 0, idle ones continue, no Tx_Done/Tx_AbortedTrans.
REQ-021 Single byte 0x55 last -> Tx=01111110 10101010 01111110; Tx_ValidFrame high for 24 cycles; Tx_Done pulse on the 24th; one Tx_NewByte.
REQ-022 Single byte 0xFF last -> Tx=01111110 111110111 01111110; 25 cycles of Tx_ValidFrame.
REQ-023 Bytes 0xF8, 0x07(last) -> data bits 00011111 0 11100000 (stuff across boundary); second Tx_NewByte one cycle late.
REQ-024 Tx_AbortFrame during bit 3 of byte 0xAA -> next Tx bits 01111111 then idle ones; Tx_AbortedTrans pulse once; Tx_Done never; no further Tx_NewByte.
REQ-025 First byte 0x00 not last, Tx_DataValid dropped at the next consumption point -> abort pattern 01111111, Tx_AbortedTrans pulse, return to IDLE.
